// File: rtl/uart_seq_detect.sv
// Sliding-window multi-byte pattern detector on a UART receive byte stream.
// Optional idle-timeout window flush is compiled in with UART_SEQ_DETECT_TIMEOUT_EN.
module uart_seq_detect #(
  parameter int unsigned                 DATA_W      = 8,
  parameter int unsigned                 SEQ_LEN     = 4,
  parameter logic [SEQ_LEN*DATA_W-1:0]   PATTERN     = 32'hDEADBEEF,
  parameter logic [SEQ_LEN*DATA_W-1:0]   MASK        = '1,
  parameter bit                          OVERLAP     = 1'b1,
  parameter int unsigned                 CNT_W       = 16,
  parameter int unsigned                 TIMEOUT_CYC = 1000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           rx_valid_i,
  input  logic [DATA_W-1:0]              rx_data_i,
  output logic                           rx_ready_o,
  input  logic                           irq_clr_i,
  output logic                           hit_o,
  output logic                           irq_o,
  output logic [CNT_W-1:0]               match_cnt_o,
  output logic [$clog2(SEQ_LEN+1)-1:0]   fill_o
);

  localparam int unsigned      WinW    = SEQ_LEN * DATA_W;
  localparam int unsigned      FillW   = $clog2(SEQ_LEN + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(SEQ_LEN);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} state_e;

  state_e           state_q;
  logic [WinW-1:0]  win_q;
  logic [WinW-1:0]  win_shift;
  logic [FillW-1:0] fill_q;
  logic [FillW-1:0] fill_inc;
  logic             hit_q;
  logic             irq_q;
  logic [CNT_W-1:0] cnt_q;
  logic             acc;
  logic             match;
  logic             flush;

  assign rx_ready_o = en_i & ~rst_i;
  assign acc        = rx_valid_i & rx_ready_o;

  // Oldest byte falls off the top; the new byte enters at the LSBs.
  assign win_shift = (win_q << DATA_W) | WinW'(rx_data_i);
  assign fill_inc  = (fill_q == FillMax) ? fill_q : fill_q + FillW'(1);
  assign match     = acc && (fill_inc == FillMax) && (((win_shift ^ PATTERN) & MASK) == '0);

`ifdef UART_SEQ_DETECT_TIMEOUT_EN
  localparam int unsigned      IdleW     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IdleW:0]   IdleLimit = (IdleW + 1)'(TIMEOUT_CYC);

  logic [IdleW-1:0] idle_q;
  logic [IdleW:0]   idle_inc;

  // Flush on the idle cycle in which the count reaches TIMEOUT_CYC; an accept always wins.
  assign idle_inc = {1'b0, idle_q} + (IdleW + 1)'(1);
  assign flush    = en_i & ~acc & (fill_q != '0) & (idle_inc == IdleLimit);

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i || acc || flush) begin
      idle_q <= '0;
    end else if (fill_q != '0) begin
      idle_q <= idle_inc[IdleW-1:0];
    end
  end
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      win_q   <= '0;
      fill_q  <= '0;
      hit_q   <= 1'b0;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hit_q <= match;
      // A new hit takes priority over a simultaneous clear.
      if (match) begin
        irq_q <= 1'b1;
      end else if (irq_clr_i) begin
        irq_q <= 1'b0;
      end
      if (match && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (acc) begin
        win_q <= win_shift;
      end
      if (!en_i || flush || (match && !OVERLAP)) begin
        state_q <= StEmpty;
        fill_q  <= '0;
      end else if (acc) begin
        fill_q <= fill_inc;
        case (state_q)
          StEmpty:   state_q <= (fill_inc == FillMax) ? StFull : StFilling;
          StFilling: if (fill_inc == FillMax) state_q <= StFull;
          default:   state_q <= StFull;
        endcase
      end
    end
  end

  assign hit_o       = hit_q;
  assign irq_o       = irq_q;
  assign match_cnt_o = cnt_q;
  assign fill_o      = fill_q;

endmodule

// File: tb/tb_uart_seq_detect.sv
// Bench for uart_seq_detect: five parameter variants share one stimulus stream and are
// compared every cycle against a queue-based reference model.
module tb_uart_seq_detect;

  localparam int N  = 5;
  localparam int TO = 10;

  logic       clk;
  logic       rst;
  logic       en;
  logic       valid;
  logic [7:0] data;
  logic       clr;

  logic        hit_w  [N];
  logic        irq_w  [N];
  logic        rdy_w  [N];
  logic [15:0] cnt_w  [N];
  logic [2:0]  fill_w [4];
  logic [0:0]  fill_one;

  int unsigned     n_cmp = 0;
  int unsigned     n_err = 0;

  int unsigned     slen [N] = '{4, 4, 4, 4, 1};
  longint unsigned pat  [N] = '{64'hDEADBEEF, 64'hAAAAAAAA, 64'hAAAAAAAA, 64'hDEADBEEF, 64'hAA};
  longint unsigned msk  [N] = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFF00FF, 64'hFF};
  bit              ovl  [N] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  byte unsigned    win    [N][$];
  bit              m_hit  [N];
  bit              m_irq  [N];
  int unsigned     m_cnt  [N];
  int unsigned     m_idle [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_seq_detect #(.TIMEOUT_CYC(TO)) u_dflt (
    .clk_i(clk), .rst_i(rst), .en_i(en), .rx_valid_i(valid), .rx_data_i(data),
    .rx_ready_o(rdy_w[0]), .irq_clr_i(clr), .hit_o(hit_w[0]), .irq_o(irq_w[0]),
    .match_cnt_o(cnt_w[0]), .fill_o(fill_w[0])
  );

  uart_seq_detect #(.PATTERN(32'hAAAAAAAA), .TIMEOUT_CYC(TO)) u_aa_ov1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .rx_valid_i(valid), .rx_data_i(data),
    .rx_ready_o(rdy_w[1]), .irq_clr_i(clr), .hit_o(hit_w[1]), .irq_o(irq_w[1]),
    .match_cnt_o(cnt_w[1]), .fill_o(fill_w[1])
  );

  uart_seq_detect #(.PATTERN(32'hAAAAAAAA), .OVERLAP(1'b0), .TIMEOUT_CYC(TO)) u_aa_ov0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .rx_valid_i(valid), .rx_data_i(data),
    .rx_ready_o(rdy_w[2]), .irq_clr_i(clr), .hit_o(hit_w[2]), .irq_o(irq_w[2]),
    .match_cnt_o(cnt_w[2]), .fill_o(fill_w[2])
  );

  uart_seq_detect #(.MASK(32'hFFFF00FF), .TIMEOUT_CYC(TO)) u_mask (
    .clk_i(clk), .rst_i(rst), .en_i(en), .rx_valid_i(valid), .rx_data_i(data),
    .rx_ready_o(rdy_w[3]), .irq_clr_i(clr), .hit_o(hit_w[3]), .irq_o(irq_w[3]),
    .match_cnt_o(cnt_w[3]), .fill_o(fill_w[3])
  );

  uart_seq_detect #(.SEQ_LEN(1), .PATTERN(8'hAA), .MASK(8'hFF), .OVERLAP(1'b0),
                    .TIMEOUT_CYC(TO)) u_one (
    .clk_i(clk), .rst_i(rst), .en_i(en), .rx_valid_i(valid), .rx_data_i(data),
    .rx_ready_o(rdy_w[4]), .irq_clr_i(clr), .hit_o(hit_w[4]), .irq_o(irq_w[4]),
    .match_cnt_o(cnt_w[4]), .fill_o(fill_one)
  );

  task automatic check_eq(input string tag, input longint unsigned got,
                          input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit window_matches(input int i);
    longint unsigned v;
    v = 0;
    foreach (win[i][k]) v = (v << 8) | longint'(win[i][k]);
    return ((v ^ pat[i]) & msk[i]) == 0;
  endfunction

  // Reference: the window is simply the list of bytes seen since the last clear.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit h;
      h = 1'b0;
      if (rst) begin
        win[i].delete();
        m_hit[i]  = 1'b0;
        m_irq[i]  = 1'b0;
        m_cnt[i]  = 0;
        m_idle[i] = 0;
      end else begin
        if (!en) begin
          win[i].delete();
          m_idle[i] = 0;
        end else if (valid) begin
          win[i].push_back(data);
          if (win[i].size() > slen[i]) void'(win[i].pop_front());
          m_idle[i] = 0;
          if (win[i].size() == slen[i] && window_matches(i)) begin
            h = 1'b1;
            if (m_cnt[i] != 32'hFFFF) m_cnt[i]++;
            if (!ovl[i]) win[i].delete();
          end
        end
`ifdef UART_SEQ_DETECT_TIMEOUT_EN
        else if (win[i].size() != 0) begin
          m_idle[i]++;
          if (m_idle[i] == TO) begin
            win[i].delete();
            m_idle[i] = 0;
          end
        end
`endif
        m_hit[i] = h;
        if (h) m_irq[i] = 1'b1;
        else if (clr) m_irq[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      logic [2:0] f;
      if (i < 4) f = fill_w[i];
      else f = {2'b00, fill_one};
      check_eq($sformatf("hit[%0d]", i), hit_w[i], m_hit[i]);
      check_eq($sformatf("irq[%0d]", i), irq_w[i], m_irq[i]);
      check_eq($sformatf("cnt[%0d]", i), cnt_w[i], m_cnt[i]);
      check_eq($sformatf("fill[%0d]", i), f, win[i].size());
    end
  endtask

  task automatic tick(input logic r, input logic e, input logic v, input logic [7:0] d,
                      input logic c);
    rst   = r;
    en    = e;
    valid = v;
    data  = d;
    clr   = c;
    #1;
    check_eq("ready", rdy_w[0], e & ~r);
    check_eq("ready_one", rdy_w[4], e & ~r);
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b0, 1'b1, 1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0]  alph [7];
    int unsigned h1;
    alph = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hAA, 8'h12, 8'hAE};
    rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0; clr = 1'b0;

    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 8'hDE, 1'b0);
    check_eq("rst_fill", fill_w[0], 0);
    check_eq("rst_cnt", cnt_w[0], 0);

    // Basic match
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    check_eq("dead_hit", hit_w[0], 1);
    check_eq("dead_irq", irq_w[0], 1);
    check_eq("dead_cnt", cnt_w[0], 1);
    check_eq("dead_fill", fill_w[0], 4);
    idle(1);
    check_eq("hit_pulse", hit_w[0], 0);

    // Clear vs simultaneous set
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    check_eq("clr_lone", irq_w[0], 0);
    send(8'hDE); send(8'hAD); send(8'hBE);
    tick(1'b0, 1'b1, 1'b1, 8'hEF, 1'b1);
    check_eq("set_wins", irq_w[0], 1);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    check_eq("clr_after", irq_w[0], 0);
    check_eq("clr_cnt", cnt_w[0], 2);

    // Overlap behaviour
    tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    h1 = 0;
    for (int k = 0; k < 6; k++) begin
      send(8'hAA);
      if (hit_w[1]) h1++;
    end
    check_eq("ov1_hits", h1, 3);
    check_eq("ov1_cnt", cnt_w[1], 3);
    check_eq("ov0_cnt", cnt_w[2], 1);
    check_eq("ov0_fill", fill_w[2], 2);
    check_eq("one_cnt", cnt_w[4], 6);

    // Don't-care byte
    send(8'hDE); send(8'hAD); send(8'h12); send(8'hEF);
    check_eq("mask_hit", hit_w[3], 1);
    check_eq("mask_nohit_dflt", hit_w[0], 0);
    send(8'hDE); send(8'hAE); send(8'h12); send(8'hEF);
    check_eq("mask_miss", hit_w[3], 0);

    // Enable drop discards the partial window
    send(8'hDE); send(8'hAD);
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("dis_fill", fill_w[0], 0);
    check_eq("dis_ready", rdy_w[0], 0);
    send(8'hBE); send(8'hEF);
    check_eq("reen_hit", hit_w[0], 0);
    check_eq("reen_fill", fill_w[0], 2);

    // Reset mid-sequence
    send(8'hDE); send(8'hAD);
    tick(1'b1, 1'b1, 1'b1, 8'hBE, 1'b0);
    check_eq("mrst_cnt", cnt_w[1], 0);
    check_eq("mrst_irq", irq_w[1], 0);
    check_eq("mrst_fill", fill_w[0], 0);

`ifdef UART_SEQ_DETECT_TIMEOUT_EN
    send(8'hDE); send(8'hAD); send(8'hBE);
    idle(TO);
    send(8'hEF);
    check_eq("to_nohit", hit_w[0], 0);
    check_eq("to_fill", fill_w[0], 1);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    send(8'hDE); send(8'hAD); send(8'hBE);
    idle(TO - 1);
    send(8'hEF);
    check_eq("to_edge_hit", hit_w[0], 1);
`else
    send(8'hDE); send(8'hAD); send(8'hBE);
    idle(TO);
    send(8'hEF);
    check_eq("persist_hit", hit_w[0], 1);
    check_eq("persist_fill", fill_w[0], 4);
`endif

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : alph[$urandom_range(0, 6)];
      if ($urandom_range(0, 99) == 0) begin
        idle($urandom_range(TO - 2, TO + 2));
      end else begin
        tick($urandom_range(0, 199) == 0, $urandom_range(0, 39) != 0,
             $urandom_range(0, 3) != 0, b, $urandom_range(0, 9) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_seq_detect.md
# uart_seq_detect

Parametrised UART byte-sequence detector. Consumes the received-byte stream from the UART receiver through a valid/ready handshake and keeps a sliding window of the last `SEQ_LEN` bytes. It compares that window against a masked `PATTERN`, raises a sticky interrupt on a match and counts matches. It sits between the UART core and the HDMI control logic. It generalises the single-byte detector to multi-byte sequences, don't-care masking, overlap control, a match counter and an optional inter-byte timeout.

## Interface
- `DATA_W`, default 8: byte width.
- `SEQ_LEN`, default 4: pattern length in bytes, at least 1.
- `PATTERN`, default `32'hDEADBEEF`: `SEQ_LEN*DATA_W` bits; the most significant byte is the oldest.
- `MASK`, default all ones: `SEQ_LEN*DATA_W` bits; a 0 bit is don't-care.
- `OVERLAP`, default 1: when 1, the window is kept after a match; when 0, the window is emptied after a match.
- `CNT_W`, default 16: match counter width.
- `TIMEOUT_CYC`, default 1000: idle cycles before the window is flushed. Used only with the timeout macro.

- `clk_i`, input, 1: clock. Single clock domain.
- `rst_i`, input, 1: **synchronous, active-high reset.**
- `en_i`, input, 1: detector enable.
- `rx_valid_i`, input, 1: received byte valid.
- `rx_data_i`, input, `DATA_W`: received byte.
- `rx_ready_o`, output, 1: byte accepted when high; equal to `en_i` outside reset.
- `irq_clr_i`, input, 1: clears `irq_o`.
- `hit_o`, output, 1: one-cycle pulse per match.
- `irq_o`, output, 1: sticky match interrupt.
- `match_cnt_o`, output, `CNT_W`: saturating match count.
- `fill_o`, output, `$clog2(SEQ_LEN+1)`: bytes currently in the window.

## Operation
- Accept: `acc = rx_valid_i & rx_ready_o`.
- Window update on accept: shift the window left by `DATA_W`, insert `rx_data_i` at the LSBs, and increment fill, saturating at `SEQ_LEN`.
- FSM, derived from fill:
  - EMPTY (fill = 0) → FILLING on accept.
  - FILLING → FULL when the accept brings fill to `SEQ_LEN`.
  - FULL stays FULL on accept.
  - With `SEQ_LEN` = 1, EMPTY goes directly to FULL.
- Match condition: `((next_window ^ PATTERN) & MASK) == 0` and next fill equals `SEQ_LEN`, evaluated only on accept.
- On a match:
  - `hit_o` is registered to 1 for exactly one cycle.
  - `irq_o` is set to 1.
  - `match_cnt_o` increments, saturating at all ones.
  - If `OVERLAP` = 0, fill returns to 0 (EMPTY) instead of staying FULL.
- `irq_o` stays high until a cycle with `irq_clr_i` = 1 and no new hit being registered. If a set and a clear occur in the same cycle, set wins.
- `en_i` = 0:
  - `rx_ready_o` = 0 and fill is cleared to 0.
  - `irq_o` and `match_cnt_o` are retained.
  - A `hit_o` already registered still completes its cycle.
- Reset:
  - `hit_o` = 0, `irq_o` = 0, `match_cnt_o` = 0, `fill_o` = 0, window = 0.
  - `rx_ready_o` = 0 during reset.
  - Reset mid-sequence discards partial window contents.
- `MASK` = 0: every accept at full fill is a match.

## Timing
- Accept at edge N → window and `fill_o` are updated after edge N.
- `hit_o`, `irq_o` and `match_cnt_o` reflect the match after the same edge N, so they are visible in cycle N+1.
- Latency from last pattern byte to interrupt is 1 cycle.
- Throughput: one byte per cycle; back-to-back accepts are supported.
- `irq_clr_i` sampled at edge M → `irq_o` is low after edge M unless a hit is also registered at M.
- `rx_ready_o` is combinational from `en_i` and the reset state only; it does not depend on `rx_valid_i`.

## Configuration
- `UART_SEQ_DETECT_TIMEOUT_EN` defined:
  - An idle counter of `$clog2(TIMEOUT_CYC+1)` bits resets to 0 on every accept.
  - It increments each cycle in which fill ≠ 0 and there is no accept.
  - When it equals `TIMEOUT_CYC` in a cycle with no accept, fill is set to 0 and the counter to 0.
  - An accept in that same cycle wins: the byte is shifted in and no flush occurs.
  - The counter is reset to 0 by reset and by `en_i` = 0.
- Macro undefined: no idle counter exists; a partial window persists indefinitely. `TIMEOUT_CYC` is ignored.

## Test plan
- Defaults: send `DE AD BE EF` back-to-back → `hit_o` pulses once, one cycle after the `EF` accept; `irq_o` = 1; `match_cnt_o` = 1; `fill_o` = 4.
- Overlap, with `PATTERN` = `32'hAAAAAAAA`: send `AA`×6.
  - `OVERLAP` = 1 → 3 hits, count 3.
  - `OVERLAP` = 0 → 1 hit, count 1, `fill_o` = 2 at the end.
- Mask: `MASK` = `32'hFFFF00FF`; send `DE AD 12 EF` → hit. Send `DE AE 12 EF` → no hit.
- Interrupt: assert `irq_clr_i` in the same cycle a hit is registered → `irq_o` stays 1. A later lone clear → `irq_o` = 0; count unchanged.
- Control: drop `en_i` after `DE AD` → `fill_o` = 0 and `rx_ready_o` = 0. Re-enable and send `BE EF` → no hit. Assert `rst_i` mid-sequence → all outputs 0.
- With `UART_SEQ_DETECT_TIMEOUT_EN`, `TIMEOUT_CYC` = 10:
  - Send `DE AD BE`, idle 10 cycles, send `EF` → no hit, `fill_o` = 1.
  - Repeat with an idle of 9 cycles → hit.
